// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a LEN/HI/LO.../CSUM byte stream into consecutive 16-bit
// big-endian word writes from address 0 and holds the CPU while a load is in progress.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {StIdle, StLen, StHi, StLo, StWrite, StCsum, StDone} state_e;

    // A LEN byte of zero stands for a full-depth load.
    localparam logic [ADDR_W:0] RemFull = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StLen;
                        addr_d  = '0;
                        err_d   = 1'b0;
                        csum_d  = '0;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        remaining_d = (in_data == 8'd0) ? RemFull : (ADDR_W+1)'(in_data);
                        state_d     = StHi;
                    end
                end
                StHi: begin
                    if (xfer) begin
                        hi_d    = in_data;
                        csum_d  = csum_q ^ in_data;
                        state_d = StLo;
                    end
                end
                StLo: begin
                    if (xfer) begin
                        wdata_d = DATA_W'({hi_q, in_data});
                        waddr_d = addr_q;
                        csum_d  = csum_q ^ in_data;
                        we_d    = 1'b1;
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    state_d     = (remaining_q == (ADDR_W+1)'(1)) ? StCsum : StHi;
                end
                StCsum: begin
                    if (xfer) begin
                        err_d   = (in_data != csum_q);
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    // An abort landing on the write cycle must still kill the write.
    assign mem_we    = we_q && !abort;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign in_ready  = (state_q == StLen) || (state_q == StHi) || (state_q == StLo) ||
                       (state_q == StCsum);
    assign busy      = (state_q != StIdle);
    assign cpu_hold  = busy;
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a packet-level model predicts every output each cycle,
// and the written memory image is compared against the model's expected image.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, busy, cpu_hold, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_mem [DEPTH];
    logic [15:0] exp_mem [DEPTH];
    logic [7:0]  q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles, done_cnt, we_cnt;
    int abort_word = -1;

    // Packet-level model: progress is tracked as bytes taken and words written.
    bit          m_active, m_wr, m_done, m_err;
    int          m_taken, m_nwords, m_words;
    logic [7:0]  m_x, m_hi;
    logic [7:0]  m_addr_out;
    logic [15:0] m_wdata_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
        return m_active && !m_wr && !m_done;
    endfunction

    task automatic model_reset();
        m_active = 0; m_wr = 0; m_done = 0; m_err = 0;
        m_taken = 0; m_nwords = 0; m_words = 0; m_x = 0; m_hi = 0;
        m_addr_out = 0; m_wdata_out = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit v, input logic [7:0] d);
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_taken = 0; m_words = 0; m_x = 0; m_err = 0;
            end
        end else if (ab) begin
            m_active = 0; m_err = 1; m_wr = 0; m_done = 0;
        end else if (m_done) begin
            m_active = 0; m_done = 0;
        end else if (m_wr) begin
            exp_mem[m_addr_out] = m_wdata_out;
            m_words++;
            m_wr = 0;
        end else if (v) begin
            if (m_taken == 0) begin
                m_nwords = (d == 8'd0) ? DEPTH : int'(d);
            end else if (m_taken <= 2 * m_nwords) begin
                m_x = m_x ^ d;
                if (m_taken % 2 == 1) begin
                    m_hi = d;
                end else begin
                    m_addr_out  = 8'(m_words % DEPTH);
                    m_wdata_out = {m_hi, d};
                    m_wr = 1;
                end
            end else begin
                m_err  = (d != m_x);
                m_done = 1;
            end
            m_taken++;
        end
    endtask

    task automatic tick(input bit st, input bit force_abort, input int stall_pct);
        bit acc;
        @(negedge clk);
        start = st;
        abort = force_abort || (m_active && m_wr && (m_words == abort_word));
        if (q.size() > 0 && $urandom_range(99) >= stall_pct) begin
            in_valid = 1'b1;
            in_data  = q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("busy", 32'(busy), 32'(m_active));
        check("cpu_hold", 32'(cpu_hold), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("mem_we", 32'(mem_we), 32'(m_wr && !abort));
        check("mem_addr", 32'(mem_addr), 32'(m_addr_out));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata_out));
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (mem_we) begin
            we_cnt++;
            dut_mem[mem_addr] = mem_wdata;
        end
        acc = m_ready() && in_valid;
        model_step(st, abort, in_valid, in_data);
        if (acc) void'(q.pop_front());
    endtask

    task automatic run_load(input int stall_pct, input bit start_noise);
        int n;
        busy_cycles = 0; done_cnt = 0; we_cnt = 0;
        tick(1'b1, 1'b0, stall_pct);
        n = 0;
        while (m_active && n < 4000) begin
            tick(start_noise && ($urandom_range(7) == 0), 1'b0, stall_pct);
            n++;
        end
        check("load_timeout", 32'(m_active), 32'd0);
        q.delete();
        tick(1'b0, 1'b0, 0);
    endtask

    task automatic build_random(input int n, input bit bad);
        logic [7:0] x, hb, lb;
        int cnt;
        cnt = (n == 0) ? DEPTH : n;
        q.delete();
        q.push_back(8'(n));
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            hb = 8'($urandom);
            lb = 8'($urandom);
            q.push_back(hb);
            q.push_back(lb);
            x = x ^ hb ^ lb;
        end
        q.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic check_image(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic basic_pkt(input logic [7:0] cs);
        q.delete();
        q.push_back(8'h02); q.push_back(8'h12); q.push_back(8'h34);
        q.push_back(8'hAB); q.push_back(8'hCD); q.push_back(cs);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 16'hDEAD;
            exp_mem[i] = 16'hDEAD;
        end
        model_reset();
        #1;
        check("por_busy", 32'(busy), 32'd0);
        check("por_in_ready", 32'(in_ready), 32'd0);
        check("por_mem_we", 32'(mem_we), 32'd0);
        check("por_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle abort must be ignored.
        tick(1'b0, 1'b1, 0);

        basic_pkt(8'h40);
        run_load(0, 1'b0);
        check("basic_mem0", 32'(dut_mem[0]), 32'h1234);
        check("basic_mem1", 32'(dut_mem[1]), 32'hABCD);
        check("basic_err", 32'(err), 32'd0);
        check("basic_busy_cycles", 32'(busy_cycles), 32'd9);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_we_cnt", 32'(we_cnt), 32'd2);
        check_image("basic_image");

        basic_pkt(8'h41);
        run_load(0, 1'b0);
        check("badcs_err", 32'(err), 32'd1);
        check("badcs_done_cnt", 32'(done_cnt), 32'd1);
        check("badcs_we_cnt", 32'(we_cnt), 32'd2);
        repeat (3) tick(1'b0, 1'b1, 0);
        check("badcs_err_sticky", 32'(err), 32'd1);

        build_random(3, 1'b0);
        run_load(50, 1'b1);
        check("stall_we_cnt", 32'(we_cnt), 32'd3);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);
        check("stall_err", 32'(err), 32'd0);
        check_image("stall_image");

        q.delete();
        q.push_back(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(8'h00);
            q.push_back(8'(i));
        end
        q.push_back(8'h00);
        run_load(0, 1'b0);
        check("full_mem255", 32'(dut_mem[255]), 32'h00FF);
        check("full_mem0", 32'(dut_mem[0]), 32'h0000);
        check("full_we_cnt", 32'(we_cnt), 32'd256);
        check("full_busy_cycles", 32'(busy_cycles), 32'd771);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check_image("full_image");

        build_random(3, 1'b0);
        abort_word = 1;
        run_load(0, 1'b1);
        abort_word = -1;
        check("abort_we_cnt", 32'(we_cnt), 32'd1);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_err", 32'(err), 32'd1);
        check("abort_busy_cycles", 32'(busy_cycles), 32'd7);
        check("abort_mem1_kept", 32'(dut_mem[1]), 32'h0001);
        check_image("abort_image");

        for (int k = 0; k < 6; k++) begin
            build_random(int'($urandom_range(1, 10)), 1'($urandom_range(1)));
            run_load(int'($urandom_range(0, 60)), 1'b1);
        end
        check_image("random_image");

        // Asynchronous reset in the middle of a load.
        build_random(4, 1'b0);
        tick(1'b1, 1'b0, 0);
        repeat (5) tick(1'b0, 1'b0, 0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        model_reset();
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        check_image("rst_image");

        basic_pkt(8'h40);
        run_load(20, 1'b0);
        check("post_rst_mem0", 32'(dut_mem[0]), 32'h1234);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
        check_image("final_image");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
